// File: rtl/rshift_mul_seq.sv
// Sequential unsigned right-shift multiplier core: one shift-and-add step per cycle,
// with the AND-gated partial product supplied by an external combinational stage.
module rshift_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     pp_a,
    output logic                 pp_b,
    input  logic [WIDTH-1:0]     pp_s,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned       CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, a_nx;
    logic [WIDTH-1:0] p_r, p_nx;
    logic [WIDTH-1:0] q_r, q_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            p_r   <= '0;
            q_r   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            a_r   <= a_nx;
            p_r   <= p_nx;
            q_r   <= q_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_r;
        p_nx     = p_r;
        q_nx     = q_r;
        cnt_nx   = cnt;
        // The carry out of the add becomes the new top bit of P after the shift.
        sum      = {1'b0, p_r} + {1'b0, pp_s};

        case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = a;
                    p_nx     = '0;
                    q_nx     = b;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                p_nx   = sum[WIDTH:1];
                q_nx   = {sum[0], q_r[WIDTH-1:1]};
                cnt_nx = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    a_nx     = a;
                    p_nx     = '0;
                    q_nx     = b;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign pp_a    = a_r;
    assign pp_b    = q_r[0];
    assign product = {p_r, q_r};
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_rshift_mul_seq.sv
// Self-checking bench for rshift_mul_seq: directed vector table, hand-written
// handshake corner cases and random operands against a plain a*b reference.
module tb_rshift_mul_seq;

    localparam int unsigned W = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [W-1:0]    pp_a;
    logic            pp_b;
    logic [W-1:0]    pp_s;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int n_checks;
    int n_fail;

    rshift_mul_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .pp_a    (pp_a),
        .pp_b    (pp_b),
        .pp_s    (pp_s),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // External partial-product AND stage, purely combinational.
    assign pp_s = pp_a & {W{pp_b}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [2*W-1:0] actual,
                         input logic [2*W-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx, yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    // Called at a negedge: drives start for this cycle, then steps one cycle at a
    // time until done is seen (or the budget runs out). Returns in the done cycle.
    // inject_at > 0 pulses a second start (a=b=1) at that cycle of the run.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int inject_at,
                          output int lat, output int bcnt, output logic [2*W-1:0] p,
                          output bit got);
        start = 1'b1;
        a     = x;
        b     = y;
        lat   = 0;
        bcnt  = 0;
        got   = 1'b0;
        p     = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
            if (n == inject_at) begin
                start = 1'b1;
                a     = 32'd1;
                b     = 32'd1;
            end
            if (busy && done) check("busy_done_overlap", 1, 0);
            if (n == 1) check("pp_a_captured", {{W{1'b0}}, pp_a}, {{W{1'b0}}, x});
            if (done) begin
                lat = n;
                p   = product;
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    int             lat, bcnt, extra_done, extra_busy;
    logic [2*W-1:0] p;
    bit             got;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{a: 32'd3,          b: 32'd5,          p: 64'h0000_0000_0000_000F};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{a: 32'd0,          b: 32'h1234_5678,  p: 64'h0};
        vecs[3] = '{a: 32'h8000_0000,  b: 32'd2,          p: 64'h0000_0001_0000_0000};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'b0, busy}, 0);
        check("reset_done", {63'b0, done}, 0);
        check("reset_product", product, 0);
        check("reset_pp_a", {{W{1'b0}}, pp_a}, 0);
        check("reset_pp_b", {63'b0, pp_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, lat, bcnt, p, got);
            check("vec_product", p, vecs[i].p);
            check("vec_latency", 64'(lat), 33);
            check("vec_busy_cycles", 64'(bcnt), 32);
            repeat (4) @(negedge clk);
            check("vec_product_held", product, vecs[i].p);
            check("vec_idle_busy", {63'b0, busy}, 0);
        end

        // Start while busy is dropped
        run_op(32'd7, 32'd9, 10, lat, bcnt, p, got);
        check("ignored_product", p, 63);
        check("ignored_latency", 64'(lat), 33);
        extra_done = 0;
        extra_busy = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check("ignored_no_second_done", 64'(extra_done), 0);
        check("ignored_no_second_busy", 64'(extra_busy), 0);

        // Back-to-back: second start issued in the done cycle of the first
        run_op(32'd2, 32'd3, 0, lat, bcnt, p, got);
        check("b2b_first_product", p, 6);
        run_op(32'd10, 32'd10, 0, lat, bcnt, p, got);
        check("b2b_second_product", p, 100);
        check("b2b_second_latency", 64'(lat), 33);
        check("b2b_second_busy", 64'(bcnt), 32);
        @(negedge clk);

        // Reset mid-operation
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'b0, busy}, 0);
        check("midrst_done", {63'b0, done}, 0);
        check("midrst_product", product, 0);
        check("midrst_pp_b", {63'b0, pp_b}, 0);
        rst = 1'b0;
        extra_done = 0;
        extra_busy = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check("midrst_no_done", 64'(extra_done), 0);
        check("midrst_no_busy", 64'(extra_busy), 0);
        run_op(32'd3, 32'd5, 0, lat, bcnt, p, got);
        check("midrst_after_product", p, 15);
        @(negedge clk);

        // Random operands against the reference product
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            if (i == 0) x = '1;
            if (i == 1) y = 32'h1;
            run_op(x, y, 0, lat, bcnt, p, got);
            check("rand_product", p, ref_mul(x, y));
            check("rand_latency", 64'(lat), 33);
            if (i % 2 == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rshift_mul_seq.md
# rshift_mul_seq

Sequential unsigned shift-and-add multiplier core for the 32-bit right-shift multiplier. Each cycle it presents the multiplicand and the current multiplier LSB to the external partial-product AND stage. It takes the gated partial product back, adds it into the high accumulator, and shifts the {accumulator, multiplier} pair right by one. The result is a 2×WIDTH product after WIDTH cycles, and a start/busy/done handshake frames each operation.

## Interface
- WIDTH, 32, operand width in bits (≥2); product is 2·WIDTH bits
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when idle or in the done cycle
- a  input  WIDTH  multiplicand, captured on accepted start
- b  input  WIDTH  multiplier, captured on accepted start
- pp_a  output  WIDTH  multiplicand register, to the partial-product stage
- pp_b  output  1  current multiplier LSB (Q[0]), to the partial-product stage
- pp_s  input  WIDTH  partial product returned, required to equal pp_a & {WIDTH{pp_b}} combinationally
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse: product valid
- product  output  2·WIDTH  result, held stable until the next accepted start

## Operation
- Registers:
  - A (WIDTH): multiplicand.
  - P (WIDTH): high accumulator.
  - Q (WIDTH): low half / multiplier.
  - cnt: ceil(log2 WIDTH) bits.
  - state.
- pp_a = A. pp_b = Q[0]. product = {P, Q}.
- States are IDLE, RUN and DONE.
- **IDLE:** on start, load A←a, P←0, Q←b, cnt←0, then go to RUN. Without start, hold everything.
- **RUN, each cycle:**
  - sum = {1'b0, P} + {1'b0, pp_s}, a (WIDTH+1)-bit add.
  - P ← sum[WIDTH:1]. Q ← {sum[0], Q[WIDTH-1:1]}. cnt ← cnt+1.
  - When cnt = WIDTH-1, go to DONE. That cycle's step is the last.
- **DONE:** lasts one cycle, with done=1.
  - If start=1 in this cycle, a new operation loads (same as the IDLE load) and the state goes to RUN.
  - Otherwise the state goes to IDLE.
- start in RUN is ignored. No queueing, no error flag.
- Arithmetic is unsigned and cannot overflow: the carry is absorbed by the shift, so P+pp fits in WIDTH+1 bits every step.
- Operands of 0 still take the full WIDTH cycles. There is no early termination.
- **Reset:**
  - state=IDLE, A=P=Q=0, cnt=0.
  - Therefore busy=0, done=0, product=0, pp_a=0, pp_b=0.
  - Reset mid-operation aborts immediately, with no done pulse. product reads 0 after reset.
- Inputs a and b are don't-care outside accepted start cycles.

## Timing
- Accepted start sampled at edge k. busy is high from after edge k through edge k+WIDTH.
- The WIDTH shift steps occur at edges k+1 … k+WIDTH.
- done is high for exactly the cycle after edge k+WIDTH. Latency from start to done is WIDTH+1 cycles (33 for the default).
- product is final from edge k+WIDTH. It is held through DONE and IDLE until the next load edge.
- On back-to-back operation (start during DONE), the next busy begins the following cycle. Throughput is one result per WIDTH+1 cycles.
- The pp_a/pp_b → pp_s path is combinational within one cycle. The external stage must not register it.
- busy and done are never high together.

## Test plan
- **Basic multiply:** reset, then start with a=3, b=5. Required: busy high for 32 cycles, done pulses once, 33 cycles after start, product=64'h0000_0000_0000_000F.
- **Maximum operands:** a=b=32'hFFFF_FFFF. Required: product=64'hFFFF_FFFE_0000_0001; checks the carry-into-shift path.
- **Zero and single-bit cases:**
  - a=0, b=32'h1234_5678 → product=0, still 33-cycle latency.
  - a=32'h8000_0000, b=2 → product=64'h0000_0001_0000_0000.
- **Ignored start while busy:** start a=7, b=9, then pulse start with a=1, b=1 at cycle 10. Required: product=63, a single done pulse, and the second request is dropped.
- **Back-to-back:** assert start with a=10, b=10 in the done cycle of an a=2, b=3 operation. Required: first product=6 on its done pulse, then 100 after a further 33 cycles, with no idle gap.
- **Reset mid-operation:** assert rst at cycle 16 of a=b=32'hFFFF_FFFF. Required: next cycle busy=0, done=0, product=0, pp_b=0; no done pulse follows; a subsequent 3×5 start returns 15.
